// File: rtl/spi_mem_bridge_pkg.sv
// Shared command codes, frame constants and FSM state type for the SPI-to-RAM bridge.
package spi_mem_bridge_pkg;

    localparam logic [7:0]  CMD_WRITE = 8'h02;
    localparam logic [7:0]  CMD_READ  = 8'h03;
    localparam int unsigned CMD_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        RDATA,
        DISCARD
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for a slow external clock pin with single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    // Top bit is the previous synchronized value, used only for edge detection.
    logic [SYNC_STAGES:0] pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= {pipe_q[SYNC_STAGES-1:0], d};
        end
    end

    assign rise = pipe_q[SYNC_STAGES-1] & ~pipe_q[SYNC_STAGES];
    assign fall = ~pipe_q[SYNC_STAGES-1] & pipe_q[SYNC_STAGES];

endmodule

// File: rtl/spi_mem_bridge.sv
// SPI mode-0 target that drives a single-port RAM; frames are cmd, addr, then data words.
// Build option: define SPI_MEM_BRIDGE_AUTOINC_EN for burst address auto-increment.
module spi_mem_bridge
    import spi_mem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  cmd_err
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    logic sclk_rise, sclk_fall;
    // Plain synchronizers assume SYNC_STAGES >= 2.
    logic [SYNC_STAGES-1:0] cs_pipe_q, mosi_pipe_q;
    logic cs_s, mosi_s;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (spi_sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_pipe_q   <= '1;
            mosi_pipe_q <= '0;
        end else begin
            cs_pipe_q   <= {cs_pipe_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_pipe_q <= {mosi_pipe_q[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign cs_s   = cs_pipe_q[SYNC_STAGES-1];
    assign mosi_s = mosi_pipe_q[SYNC_STAGES-1];

    state_t                state_q, state_d;
    logic                  rd_mode_q, rd_mode_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  miso_q, miso_d;
    logic                  busy_q, busy_d;
    logic                  cmd_err_q, cmd_err_d;
    logic [DATA_WIDTH-1:0] rx_next;

    always_comb begin
        state_d     = state_q;
        rd_mode_d   = rd_mode_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rd_pend_d   = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        miso_d      = miso_q;
        busy_d      = busy_q;
        cmd_err_d   = 1'b0;
        rx_next     = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

`ifdef SPI_MEM_BRIDGE_AUTOINC_EN
        if (mem_we_q) begin
            mem_addr_d = mem_addr_q + 1'b1;
        end
`endif
        if (rd_pend_q) begin
            mem_en_d = 1'b1;
        end
        // Read strobe cycle: capture the word and present its MSB ahead of the first rise.
        if (mem_en_q && !mem_we_q && state_q == RDATA) begin
            tx_shift_d = mem_rdata;
            miso_d     = mem_rdata[DATA_WIDTH-1];
        end

        unique case (state_q)
            IDLE: begin
                if (!cs_s) begin
                    state_d   = CMD;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            CMD: begin
                if (sclk_rise) begin
                    rx_shift_d = rx_next;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(CMD_BITS - 1)) begin
                        bit_cnt_d = '0;
                        if (rx_next[7:0] == CMD_WRITE) begin
                            state_d   = ADDR;
                            rd_mode_d = 1'b0;
                        end else if (rx_next[7:0] == CMD_READ) begin
                            state_d   = ADDR;
                            rd_mode_d = 1'b1;
                        end else begin
                            state_d   = DISCARD;
                            cmd_err_d = 1'b1;
                        end
                    end
                end
            end
            ADDR: begin
                if (sclk_rise) begin
                    rx_shift_d = rx_next;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(CMD_BITS - 1)) begin
                        bit_cnt_d  = '0;
                        mem_addr_d = rx_next[ADDR_WIDTH-1:0];
                        if (rd_mode_q) begin
                            state_d  = RDATA;
                            mem_en_d = 1'b1;
                        end else begin
                            state_d = WDATA;
                        end
                    end
                end
            end
            WDATA: begin
                if (sclk_rise) begin
                    rx_shift_d = rx_next;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d   = '0;
                        mem_wdata_d = rx_next;
                        mem_en_d    = 1'b1;
                        mem_we_d    = 1'b1;
                    end
                end
            end
            RDATA: begin
                if (sclk_rise) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        rd_pend_d = 1'b1;
`ifdef SPI_MEM_BRIDGE_AUTOINC_EN
                        mem_addr_d = mem_addr_q + 1'b1;
`endif
                    end
                end else if (sclk_fall && bit_cnt_q != '0) begin
                    // Falls that precede a word's first rise must not advance the shifter.
                    tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    miso_d     = tx_shift_q[DATA_WIDTH-2];
                end
            end
            DISCARD: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cs_s && state_q != IDLE) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            rd_pend_d = 1'b0;
        end
        if (state_d != RDATA) begin
            miso_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_mode_q   <= 1'b0;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rd_pend_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_mode_q   <= rd_mode_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rd_pend_q   <= rd_pend_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            miso_q      <= miso_d;
            busy_q      <= busy_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign spi_miso  = miso_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Bench for spi_mem_bridge: SPI host tasks, RAM behind the port and a word-level memory model.
module tb_spi_mem_bridge;

`ifdef SPI_MEM_BRIDGE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_sclk, spi_cs_n, spi_mosi, spi_miso;
    logic        mem_en, mem_we, busy, cmd_err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] ram     [0:255];
    logic [31:0] exp_ram [0:255];

    int tests = 0;
    int fails = 0;
    int en_cnt = 0, we_cnt = 0, err_cnt = 0, miso_hi = 0;
    int en_run_bad = 0, we_bad = 0, err_run_bad = 0;
    logic prev_en = 1'b0, prev_err = 1'b0;
    logic [7:0]  waddr_log[$];
    logic [31:0] wdata_log[$];
    logic [31:0] wq[$];

    always #5 clk = ~clk;

    spi_mem_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_sclk  (spi_sclk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    end

    // Port monitor, sampled on the inactive clock edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_en) en_cnt++;
            if (mem_en && prev_en) en_run_bad++;
            if (mem_we && !mem_en) we_bad++;
            if (mem_en && mem_we) begin
                we_cnt++;
                waddr_log.push_back(mem_addr);
                wdata_log.push_back(mem_wdata);
            end
            if (cmd_err) err_cnt++;
            if (cmd_err && prev_err) err_run_bad++;
            if (spi_miso) miso_hi++;
            prev_en  = mem_en;
            prev_err = cmd_err;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " mem_en"}, 64'(mem_en), 64'd0);
        check({tag, " mem_we"}, 64'(mem_we), 64'd0);
        check({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, " spi_miso"}, 64'(spi_miso), 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " cmd_err"}, 64'(cmd_err), 64'd0);
    endtask

    task automatic shift_bits(input logic [31:0] d, input int n, output logic [31:0] r);
        r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = d[i];
            #50;
            spi_sclk = 1'b1;
            r[i] = spi_miso;
            #50;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic frame_begin();
        spi_cs_n = 1'b0;
        #60;
    endtask

    task automatic frame_end();
        #50;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        #100;
    endtask

    task automatic compare_ram(input string tag);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== exp_ram[i]) bad++;
        check(tag, 64'(bad), 64'd0);
    endtask

    // Writes the words in wq as one frame and updates the memory model.
    task automatic do_write(input string tag, input logic [7:0] a);
        logic [31:0] r;
        logic [7:0]  aa = a;
        int          we0 = we_cnt;
        frame_begin();
        check({tag, " busy in frame"}, 64'(busy), 64'd1);
        shift_bits(32'h02, 8, r);
        shift_bits(32'(a), 8, r);
        foreach (wq[k]) begin
            shift_bits(wq[k], 32, r);
            exp_ram[aa] = wq[k];
            if (AUTOINC) aa = aa + 8'd1;
        end
        frame_end();
        check({tag, " write strobes"}, 64'(we_cnt - we0), 64'(wq.size()));
        check({tag, " busy after"}, 64'(busy), 64'd0);
        compare_ram({tag, " ram"});
    endtask

    task automatic do_read(input string tag, input logic [7:0] a, input int n);
        logic [31:0] r;
        logic [7:0]  aa = a;
        int          en0 = en_cnt;
        int          we0 = we_cnt;
        frame_begin();
        shift_bits(32'h03, 8, r);
        shift_bits(32'(a), 8, r);
        for (int k = 0; k < n; k++) begin
            shift_bits($urandom, 32, r);
            check($sformatf("%s word%0d", tag, k), 64'(r), 64'(exp_ram[aa]));
            if (AUTOINC) aa = aa + 8'd1;
        end
        frame_end();
        check({tag, " read strobes"}, 64'(en_cnt - en0), 64'(n + 1));
        check({tag, " no write"}, 64'(we_cnt - we0), 64'd0);
    endtask

    initial begin
        logic [31:0] r;
        int en0, err0, mh0, we0;
        for (int i = 0; i < 256; i++) begin
            r = $urandom;
            ram[i] = r;
            exp_ram[i] = r;
        end
        rst_n = 1'b0;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        #20;
        check_reset("reset");
        #20;
        rst_n = 1'b1;
        #40;
        check_reset("after reset");

        // Directed write burst
        waddr_log.delete();
        wdata_log.delete();
        wq = '{32'hDEADBEEF, 32'h12345678};
        do_write("wr burst", 8'h10);
        check("wr burst addr0", 64'(waddr_log[0]), 64'h10);
        check("wr burst data0", 64'(wdata_log[0]), 64'hDEADBEEF);
        check("wr burst addr1", 64'(waddr_log[1]), AUTOINC ? 64'h11 : 64'h10);
        check("wr burst data1", 64'(wdata_log[1]), 64'h12345678);

        // Directed read burst
        ram[8'h20] = 32'hCAFEF00D; exp_ram[8'h20] = 32'hCAFEF00D;
        ram[8'h21] = 32'h00000001; exp_ram[8'h21] = 32'h00000001;
        do_read("rd burst", 8'h20, 2);

        // Illegal command
        en0 = en_cnt; err0 = err_cnt; mh0 = miso_hi;
        frame_begin();
        shift_bits(32'h5A, 8, r);
        shift_bits(32'h00, 8, r);
        shift_bits(32'hFFFFFFFF, 32, r);
        check("illegal busy", 64'(busy), 64'd1);
        frame_end();
        check("illegal cmd_err", 64'(err_cnt - err0), 64'd1);
        check("illegal no mem_en", 64'(en_cnt - en0), 64'd0);
        check("illegal miso low", 64'(miso_hi - mh0), 64'd0);
        check("illegal busy after", 64'(busy), 64'd0);

        // Abort mid-word, then a normal frame
        we0 = we_cnt;
        frame_begin();
        shift_bits(32'h02, 8, r);
        shift_bits(32'h05, 8, r);
        shift_bits($urandom, 17, r);
        frame_end();
        check("abort no write", 64'(we_cnt - we0), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        compare_ram("abort ram");
        wq = '{$urandom};
        do_write("post abort", 8'h05);

        // Address wrap
        wq = '{$urandom, $urandom};
        do_write("wrap", 8'hFF);
        check("wrap ram[0]", 64'(ram[8'h00]), 64'(exp_ram[8'h00]));
        do_read("wrap rd", 8'hFF, 2);

        // Random frames
        for (int f = 0; f < 6; f++) begin
            logic [7:0] a = 8'($urandom);
            int n = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 0) begin
                wq.delete();
                for (int k = 0; k < n; k++) wq.push_back($urandom);
                do_write($sformatf("rand wr%0d", f), a);
            end else begin
                do_read($sformatf("rand rd%0d", f), a, n);
            end
        end

        // Reset during read data
        frame_begin();
        shift_bits(32'h03, 8, r);
        shift_bits(32'h20, 8, r);
        shift_bits(32'h0, 10, r);
        #20;
        rst_n = 1'b0;
        #1;
        check_reset("mid-read reset");
        #19;
        spi_cs_n = 1'b1;
        #50;
        rst_n = 1'b1;
        #50;
        check("post reset busy", 64'(busy), 64'd0);
        compare_ram("post reset ram");
        do_read("post reset rd", 8'h21, 1);

        check("mem_en single cycle", 64'(en_run_bad), 64'd0);
        check("mem_we implies mem_en", 64'(we_bad), 64'd0);
        check("cmd_err single cycle", 64'(err_run_bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
